gcd_unit: RTL



---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_sub_cmp.sv | 19 +
 rtl/gcd_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared state encoding and mode constants for the GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_EUCLID = 1'b0;
    localparam logic MODE_BINARY = 1'b1;

    // Width of the common-power-of-two counter used by the binary algorithm.
    function automatic int k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_sub_cmp.sv
// Combinational magnitude compare of two operands plus |a-b| (larger minus smaller).
// Zero latency; no handshake.
module gcd_sub_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic [WIDTH-1:0] diff
);

    assign lt   = (a < b);
    assign gt   = (a > b);
    assign eq   = (a == b);
    assign diff = gt ? (a - b) : (b - a);

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD, subtractive Euclid or binary Stein, one step per cycle.
// done pulses N+2 edges after the accepting edge; start is ignored unless IDLE.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_err,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam int K_W = k_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_err_q, zero_err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;

    logic             cmp_lt, cmp_gt, cmp_eq;
    logic [WIDTH-1:0] cmp_diff;

    gcd_sub_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a    (a_q),
        .b    (b_q),
        .lt   (cmp_lt),
        .gt   (cmp_gt),
        .eq   (cmp_eq),
        .diff (cmp_diff)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        zero_err_d = zero_err_q;
        result_d   = result_q;
        iter_cnt_d = iter_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    mode_d     = mode;
                    k_d        = '0;
                    iter_cnt_d = '0;
                    result_d   = '0;
                    zero_err_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                if (a_q == '0 || b_q == '0) begin
                    result_d   = a_q | b_q;
                    zero_err_d = (a_q == '0) && (b_q == '0);
                    state_d    = ST_DONE;
                end else if (cmp_eq) begin
                    // Binary mode restores the common power of two stripped earlier.
                    result_d = a_q << k_q;
                    state_d  = ST_DONE;
                end else begin
                    if (iter_cnt_q != '1) begin
                        iter_cnt_d = iter_cnt_q + 1'b1;
                    end
                    if (mode_q == MODE_BINARY && !a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + 1'b1;
                    end else if (mode_q == MODE_BINARY && !a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (mode_q == MODE_BINARY && !b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (cmp_gt) begin
                        a_d = cmp_diff;
                    end else if (cmp_lt) begin
                        b_d = cmp_diff;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            mode_q     <= MODE_EUCLID;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            zero_err_q <= 1'b0;
            result_q   <= '0;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            zero_err_q <= zero_err_d;
            result_q   <= result_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero_err = zero_err_q;
    assign iter_cnt = iter_cnt_q;

endmodule
